// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM states and default width for alu_seq      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   // Opcodes shared with the ALU decoder
   localparam logic [2:0] ADD_ALU = 3'b000;
   localparam logic [2:0] SUB_ALU = 3'b001;
   localparam logic [2:0] AND_ALU = 3'b010;
   localparam logic [2:0] OR_ALU  = 3'b011;
   localparam logic [2:0] XOR_ALU = 3'b100;
   localparam logic [2:0] SLT_ALU = 3'b101;
   localparam logic [2:0] SHL_ALU = 3'b110;
   localparam logic [2:0] SHR_ALU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } alu_state_t;

   function automatic logic is_shift_op(input logic [2:0] op);
      return (op == SHL_ALU) || (op == SHR_ALU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_core : combinational single-cycle ADD/SUB/AND/OR/XOR/SLT     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [2:0]       ctrl_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   always_comb begin
      y_o = '0;
      unique case (ctrl_i)
         ADD_ALU: y_o = a_i + b_i;
         SUB_ALU: y_o = a_i - b_i;
         AND_ALU: y_o = a_i & b_i;
         OR_ALU:  y_o = a_i | b_i;
         XOR_ALU: y_o = a_i ^ b_i;
         SLT_ALU: y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         default: y_o = '0;   // shifts are handled by the sequencer
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_seq : registered ALU with start/busy/done, bit-serial shifts |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   alu_state_t       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] core_y;
   logic [WIDTH-1:0] acc_shift;
   logic [SHW-1:0]   shamt;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .ctrl_i (alu_control),
      .a_i    (src_a),
      .b_i    (src_b),
      .y_o    (core_y)
   );

   assign shamt     = src_b[SHW-1:0];
   assign acc_shift = (op_q == SHL_ALU) ? {acc_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, acc_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= ADD_ALU;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d = alu_control;
               if (!is_shift_op(alu_control)) begin
                  result_d = core_y;
                  state_d  = ST_DONE;
               end else if (shamt == '0) begin
                  result_d = src_a;
                  state_d  = ST_DONE;
               end else begin
                  acc_d   = src_a;
                  cnt_d   = shamt;
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            acc_d = acc_shift;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               result_d = acc_shift;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // result_d equals result_q except on the edge entering DONE
      zero_d = (result_d == '0);
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign zero   = zero_q;

endmodule
`default_nettype wire
